// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: one shared 64-bit shift/add-subtract
// datapath, 32 iterations per operation, fast path for divide-by-zero and overflow.
module muldiv_seq #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              flush_i,
    input  logic [2:0]        funct3_i,
    input  logic [DWIDTH-1:0] rs1_i,
    input  logic [DWIDTH-1:0] rs2_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DWIDTH-1:0] res_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DWIDTH-1:0] INT_MIN  = {1'b1, {(DWIDTH-1){1'b0}}};
    localparam logic [5:0]        LAST_IT  = 6'(DWIDTH - 1);

    state_t              state_q;
    logic [2:0]          funct3_q;
    logic                neg1_q, neg2_q;
    logic [DWIDTH-1:0]   opnd_q;     // multiplicand (mul) or divisor (div)
    logic [2*DWIDTH-1:0] acc_q;      // {partial product | remainder, multiplier | quotient}
    logic [5:0]          cnt_q;
    logic [DWIDTH-1:0]   res_q;

    // Accept-side decode: sign flags, magnitudes and fast-path results.
    logic              sign1, sign2, neg1, neg2;
    logic [DWIDTH-1:0] mag1, mag2;
    logic              fast_zero, fast_ovf;
    logic [DWIDTH-1:0] fast_res;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sign1 = 1'b0;
        sign2 = 1'b0;
        case (funct3_i)
            3'b001, 3'b100, 3'b110: begin sign1 = 1'b1; sign2 = 1'b1; end
            3'b010:                 sign1 = 1'b1;
            default:                ;
        endcase
        neg1 = sign1 & rs1_i[DWIDTH-1];
        neg2 = sign2 & rs2_i[DWIDTH-1];
        mag1 = neg1 ? -rs1_i : rs1_i;
        mag2 = neg2 ? -rs2_i : rs2_i;

        fast_zero = funct3_i[2] && (rs2_i == '0);
        fast_ovf  = funct3_i[2] && !funct3_i[0] && (rs1_i == INT_MIN) && (rs2_i == '1);
        fast_res  = '0;
        if (fast_zero)
            fast_res = funct3_i[1] ? rs1_i : '1;
        else if (fast_ovf)
            fast_res = funct3_i[1] ? '0 : INT_MIN;
    end

    // One iteration of either algorithm, plus the signed result of the final one.
    logic [DWIDTH:0]     mul_sum;
    logic [DWIDTH:0]     rem_sh;
    logic                rem_ge;
    logic [DWIDTH-1:0]   rem_diff;
    logic [2*DWIDTH-1:0] acc_d;
    logic [2*DWIDTH-1:0] prod_s;
    logic [DWIDTH-1:0]   quo_s, rem_s, res_d;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*DWIDTH-1:DWIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = {acc_q[2*DWIDTH-1:DWIDTH], acc_q[DWIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, opnd_q};
        // When rem_ge holds the difference is below the divisor, so DWIDTH bits suffice.
        rem_diff = rem_sh[DWIDTH-1:0] - opnd_q;

        if (funct3_q[2])
            acc_d = {(rem_ge ? rem_diff : rem_sh[DWIDTH-1:0]), acc_q[DWIDTH-2:0], rem_ge};
        else
            acc_d = {mul_sum, acc_q[DWIDTH-1:1]};

        prod_s = (neg1_q ^ neg2_q) ? -acc_d : acc_d;
        quo_s  = (neg1_q ^ neg2_q) ? -acc_d[DWIDTH-1:0] : acc_d[DWIDTH-1:0];
        rem_s  = neg1_q ? -acc_d[2*DWIDTH-1:DWIDTH] : acc_d[2*DWIDTH-1:DWIDTH];

        case (funct3_q)
            3'b000:         res_d = prod_s[DWIDTH-1:0];
            3'b100, 3'b101: res_d = quo_s;
            3'b110, 3'b111: res_d = rem_s;
            default:        res_d = prod_s[2*DWIDTH-1:DWIDTH];
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else if (start_i) begin
                        funct3_q <= funct3_i;
                        neg1_q   <= neg1;
                        neg2_q   <= neg2;
                        cnt_q    <= '0;
                        if (funct3_i[2]) begin
                            opnd_q <= mag2;
                            acc_q  <= {{DWIDTH{1'b0}}, mag1};
                        end else begin
                            opnd_q <= mag1;
                            acc_q  <= {{DWIDTH{1'b0}}, mag2};
                        end
                        if (fast_zero || fast_ovf) begin
                            res_q   <= fast_res;
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == LAST_IT) begin
                            res_q   <= res_d;
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == CALC);
    assign done_o = (state_q == DONE);
    assign res_o  = res_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq: results, latencies, fast path,
// back-to-back issue, flush and asynchronous reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i, flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        busy_o, done_o;
    logic [31:0] res_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011,
                           DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    muldiv_seq #(.DWIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .funct3_i (funct3_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .res_o    (res_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble operands after accept, wait for done_o (bounded).
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input int exp_lat, input int exp_busy);
        int lat, busy_cnt;
        @(negedge clk);
        start_i = 1'b1; funct3_i = f3; rs1_i = a; rs2_i = b;
        @(negedge clk);
        start_i = 1'b0; rs1_i = 32'hDEAD_BEEF; rs2_i = 32'h1234_5678; funct3_i = 3'b011;
        lat = 1; busy_cnt = 0;
        while (!done_o && lat < 100) begin
            if (busy_o) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " result"}, res_o, exp_res);
    endtask

    // Count done_o pulses over a window where none may appear.
    task automatic expect_no_done(input string tag, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int gap;
        reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct3_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset done", 32'(done_o), 32'd0);
        check("reset res",  res_o, 32'd0);
        reset = 1'b0;

        // Multiply family
        run_op("MUL 7*-3",        MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 32);
        run_op("MUL low wrap",    MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780, 33, 32);
        run_op("MULH min*min",    MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 32);
        run_op("MULHU 2^31*2^31", MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 32);
        run_op("MULHSU -1*max",   MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32);

        // Divide family
        run_op("DIV -7/2",        DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 32);
        run_op("REM -7/2",        REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 32);
        run_op("DIVU 100/7",      DIVU,   32'd100,        32'd7,         32'd14,        33, 32);
        run_op("REMU 100/7",      REMU,   32'd100,        32'd7,         32'd2,         33, 32);
        run_op("DIV 100/-7",      DIV,    32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 32);
        run_op("REM 100/-7",      REM,    32'd100,        32'hFFFF_FFF9, 32'd2,         33, 32);

        // Fast path
        run_op("DIVU 5/0",        DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1, 0);
        run_op("REM 5/0",         REM,    32'd5,          32'd0,         32'd5,         1, 0);
        run_op("DIV ovf",         DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op("REM ovf",         REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 0);

        // Back-to-back: MUL 3*4, then DIVU 12/4 issued during the DONE cycle
        run_op("B2B MUL 3*4",     MUL,    32'd3,          32'd4,         32'd12,        33, 32);
        start_i = 1'b1; funct3_i = DIVU; rs1_i = 32'd12; rs2_i = 32'd4;
        @(negedge clk);
        start_i = 1'b0;
        check("B2B no bubble", 32'(busy_o), 32'd1);
        gap = 1;
        while (!done_o && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        check("B2B done gap", 32'(gap), 32'd33);
        check("B2B DIVU 12/4", res_o, 32'd3);

        // Flush at iteration 10 of a DIV; res_o keeps 3 from the previous op
        @(negedge clk);
        start_i = 1'b1; funct3_i = DIV; rs1_i = 32'd1000; rs2_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush busy", 32'(busy_o), 32'd0);
        check("flush done", 32'(done_o), 32'd0);
        check("flush res",  res_o, 32'd3);
        expect_no_done("flush no done", 40);
        run_op("post-flush DIVU", DIVU,   32'd100,        32'd7,         32'd14,        33, 32);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        start_i = 1'b1; funct3_i = MUL; rs1_i = 32'd9; rs2_i = 32'd9;
        @(negedge clk);
        start_i = 1'b0;
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async rst busy", 32'(busy_o), 32'd0);
        check("async rst done", 32'(done_o), 32'd0);
        check("async rst res",  res_o, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        expect_no_done("rst no done", 40);
        run_op("post-rst MUL",    MUL,    32'd6,          32'd7,         32'd42,        33, 32);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
